shallow_fifo_sync_mode: RTL and testbench

//  Next-generation shallow synchronous FIFO on distributed RAM (xilinx_dp_distram).

---
 rtl/shallow_fifo_sync_mode_if.sv | 41 ++++
 rtl/shallow_fifo_sync_mode.sv | 106 ++++++++++
 tb/tb_shallow_fifo_sync_mode.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shallow_fifo_sync_mode_if.sv
// shallow_fifo_sync_mode_if: write/read/status bundle of the shallow FIFO.
// parity_err exists only when SHALLOW_FIFO_PARITY_EN is defined.
interface shallow_fifo_sync_mode_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 6
);
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   full;
    logic                   prog_full;
    logic                   overflow;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   empty;
    logic                   prog_empty;
    logic                   underflow;
    logic [COUNT_WIDTH-1:0] count;
`ifdef SHALLOW_FIFO_PARITY_EN
    logic                   parity_err;
    modport master (
        output wr_en, wr_data, rd_en,
        input  full, prog_full, overflow, rd_data, rd_valid, empty, prog_empty, underflow, count,
               parity_err
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, prog_full, overflow, rd_data, rd_valid, empty, prog_empty, underflow, count,
               parity_err
    );
`else
    modport master (
        output wr_en, wr_data, rd_en,
        input  full, prog_full, overflow, rd_data, rd_valid, empty, prog_empty, underflow, count
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, prog_full, overflow, rd_data, rd_valid, empty, prog_empty, underflow, count
    );
`endif
endinterface

// File: rtl/shallow_fifo_sync_mode.sv
// shallow_fifo_sync_mode: shallow sync FIFO on distributed RAM, standard or FWFT read mode.
// Optional even-parity protection of stored words with SHALLOW_FIFO_PARITY_EN.
module shallow_fifo_sync_mode #(
    parameter int DATA_WIDTH        = 8,
    parameter int FIFO_DEPTH        = 32,
    parameter int FWFT              = 0,
    parameter int PROG_FULL_THRESH  = 8,
    parameter int PROG_EMPTY_THRESH = 8,
    parameter int COUNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
    input logic                     clk,
    input logic                     rst,
    shallow_fifo_sync_mode_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
`ifdef SHALLOW_FIFO_PARITY_EN
    localparam int RAM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int RAM_WIDTH = DATA_WIDTH;
`endif
    localparam logic [0:0] EMPTY_S = 1'b0;
    localparam logic [0:0] VALID_S = 1'b1;

    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 4..64");
    end

    logic [RAM_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [RAM_WIDTH-1:0]   wr_word;
    logic [RAM_WIDTH-1:0]   ram_word;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [0:0]             state;
    logic                   std_valid;
    logic                   overflow;
    logic                   underflow;
    logic                   head;
    logic                   full;
    logic                   empty;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   ram_has;
    logic                   load;

`ifdef SHALLOW_FIFO_PARITY_EN
    logic parity_err;
    assign wr_word = {^bus.wr_data, bus.wr_data};
    assign bus.parity_err = parity_err;
`else
    assign wr_word = bus.wr_data;
`endif

    assign ram_word = mem[rd_ptr];
    assign head     = state == VALID_S;
    assign full     = count == COUNT_WIDTH'(FIFO_DEPTH);
    assign empty    = FWFT != 0 ? ~head : count == '0;
    assign wr_acc   = bus.wr_en & ~full;
    assign rd_acc   = bus.rd_en & ~empty;
    // In FWFT mode count includes the output register, so the RAM holds count minus head.
    assign ram_has  = FWFT != 0 ? (count - COUNT_WIDTH'(head)) != '0 : count != '0;
    assign load     = FWFT != 0 ? ram_has & (~head | rd_acc) : rd_acc;

    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= wr_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            state     <= EMPTY_S;
            std_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (load) begin
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
                rd_data <= ram_word[DATA_WIDTH-1:0];
            end
            count     <= count + COUNT_WIDTH'(wr_acc) - COUNT_WIDTH'(rd_acc);
            state     <= FWFT == 0 ? EMPTY_S : load ? VALID_S : rd_acc ? EMPTY_S : state;
            std_valid <= FWFT == 0 && rd_acc;
            overflow  <= bus.wr_en & full;
            underflow <= bus.rd_en & empty;
        end
    end

`ifdef SHALLOW_FIFO_PARITY_EN
    always_ff @(posedge clk)
        parity_err <= rst ? 1'b0 : load & ^ram_word;
`endif

    assign bus.rd_data    = rd_data;
    assign bus.rd_valid   = FWFT != 0 ? head : std_valid;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = count;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;
    assign bus.prog_full  = int'(count) >= FIFO_DEPTH - PROG_FULL_THRESH;
    assign bus.prog_empty = int'(count) <= PROG_EMPTY_THRESH;
endmodule

// File: tb/tb_shallow_fifo_sync_mode.sv
// tb_shallow_fifo_sync_mode: table vectors plus scoreboard checks of standard and FWFT instances.
module tb_shallow_fifo_sync_mode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int mcount = 0;
    logic [7:0] sq[$];
    logic [7:0] fq[$];

    typedef struct {
        bit w;
        logic [7:0] d;
        bit r;
        int cnt;
        bit empty;
        bit un;
        bit valid;
    } vec_t;
    vec_t vecs[9];

    shallow_fifo_sync_mode_if #(.DATA_WIDTH(8), .COUNT_WIDTH(6)) ms();
    shallow_fifo_sync_mode_if #(.DATA_WIDTH(8), .COUNT_WIDTH(6)) mf();

    shallow_fifo_sync_mode #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .FWFT(0)) dut_s (
        .clk(clk), .rst(rst), .bus(ms)
    );
    shallow_fifo_sync_mode #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .bus(mf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic std_cyc(input bit w, input logic [7:0] d, input bit r);
        bit wa, ra;
        logic [7:0] e;
        wa = w && mcount != 32;
        ra = r && mcount != 0;
        ms.wr_en = w;
        ms.wr_data = d;
        ms.rd_en = r;
        tick();
        ms.wr_en = 1'b0;
        ms.rd_en = 1'b0;
        chk("overflow", ms.overflow, int'(w && !wa));
        chk("underflow", ms.underflow, int'(r && !ra));
        chk("rd_valid", ms.rd_valid, int'(ra));
        if (ms.rd_valid) begin
            if (sq.size() == 0) chk("rd_spurious", 1, 0);
            else begin
                e = sq.pop_front();
                chk("rd_data", ms.rd_data, e);
            end
        end
        if (wa) sq.push_back(d);
        mcount = mcount + int'(wa) - int'(ra);
        chk("count", ms.count, mcount);
        chk("full", ms.full, int'(mcount == 32));
        chk("empty", ms.empty, int'(mcount == 0));
        chk("prog_full", ms.prog_full, int'(mcount >= 24));
        chk("prog_empty", ms.prog_empty, int'(mcount <= 8));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sq.delete();
        fq.delete();
        mcount = 0;
    endtask

    initial begin
        logic [7:0] e;
        vecs = '{
            '{0, 8'h00, 1, 0, 1, 1, 0},
            '{1, 8'h11, 0, 1, 0, 0, 0},
            '{1, 8'h22, 1, 1, 0, 0, 1},
            '{1, 8'h33, 0, 2, 0, 0, 0},
            '{0, 8'h00, 1, 1, 0, 0, 1},
            '{0, 8'h00, 1, 0, 1, 0, 1},
            '{1, 8'h44, 1, 1, 0, 1, 0},
            '{0, 8'h00, 1, 0, 1, 0, 1},
            '{0, 8'h00, 0, 0, 1, 0, 0}
        };
        ms.wr_en = 1'b0; ms.wr_data = '0; ms.rd_en = 1'b0;
        mf.wr_en = 1'b0; mf.wr_data = '0; mf.rd_en = 1'b0;
        tick();
        tick();
        chk("rst_count", ms.count, 0);
        chk("rst_empty", ms.empty, 1);
        chk("rst_prog_empty", ms.prog_empty, 1);
        chk("rst_full", ms.full, 0);
        chk("rst_prog_full", ms.prog_full, 0);
        chk("rst_rd_valid", ms.rd_valid, 0);
        chk("rst_rd_data", ms.rd_data, 0);
        chk("rst_overflow", ms.overflow, 0);
        chk("rst_underflow", ms.underflow, 0);
        chk("rst_f_empty", mf.empty, 1);
        chk("rst_f_rd_valid", mf.rd_valid, 0);
        chk("rst_f_count", mf.count, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            std_cyc(vecs[i].w, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d_count", i), ms.count, vecs[i].cnt);
            chk($sformatf("vec%0d_empty", i), ms.empty, int'(vecs[i].empty));
            chk($sformatf("vec%0d_underflow", i), ms.underflow, int'(vecs[i].un));
            chk($sformatf("vec%0d_rd_valid", i), ms.rd_valid, int'(vecs[i].valid));
        end

        for (int i = 0; i < 5; i++) std_cyc(1, 8'(8'h50 + i), 0);
        do_reset();
        chk("midrst_count", ms.count, 0);
        chk("midrst_empty", ms.empty, 1);
        chk("midrst_rd_valid", ms.rd_valid, 0);
        std_cyc(0, 8'h00, 1);

        for (int i = 0; i < 32; i++) std_cyc(1, 8'(i), 0);
        chk("fill_full", ms.full, 1);
        std_cyc(1, 8'hEE, 0);
        chk("fill_ovf_count", ms.count, 32);
        for (int i = 0; i < 32; i++) std_cyc(0, 8'h00, 1);

        for (int i = 0; i < 32; i++) std_cyc(1, 8'(8'h40 + i), 0);
        std_cyc(1, 8'hEE, 1);
        chk("simul_count", ms.count, 31);
        chk("simul_ovf", ms.overflow, 1);
        chk("simul_data", ms.rd_data, 8'h40);
        for (int i = 0; i < 31; i++) std_cyc(0, 8'h00, 1);

        for (int i = 0; i < 3; i++) std_cyc(1, 8'(i), 0);
        for (int i = 0; i < 100; i++) begin
            std_cyc(1, 8'(3 + i), 1);
            chk("wrap_count", ms.count, 3);
        end
        for (int i = 0; i < 3; i++) std_cyc(0, 8'h00, 1);

        do_reset();
        mf.wr_en = 1'b1; mf.wr_data = 8'hA5;
        tick();
        mf.wr_en = 1'b0;
        chk("fw_valid_n", mf.rd_valid, 0);
        chk("fw_empty_n", mf.empty, 1);
        chk("fw_count_n", mf.count, 1);
        tick();
        chk("fw_valid", mf.rd_valid, 1);
        chk("fw_data", mf.rd_data, 8'hA5);
        chk("fw_empty", mf.empty, 0);
        tick();
        chk("fw_hold", mf.rd_valid, 1);
        mf.rd_en = 1'b1;
        tick();
        mf.rd_en = 1'b0;
        chk("fw_ack_valid", mf.rd_valid, 0);
        chk("fw_ack_count", mf.count, 0);
        chk("fw_ack_empty", mf.empty, 1);

        for (int i = 0; i < 32; i++) begin
            mf.wr_en = 1'b1; mf.wr_data = 8'(8'h80 + i);
            fq.push_back(mf.wr_data);
            tick();
        end
        chk("fw_full", mf.full, 1);
        chk("fw_count_full", mf.count, 32);
        mf.wr_data = 8'hFF;
        tick();
        mf.wr_en = 1'b0;
        chk("fw_overflow", mf.overflow, 1);
        chk("fw_count_ovf", mf.count, 32);
        chk("fw_prog_full", mf.prog_full, 1);
        for (int i = 0; i < 32; i++) begin
            chk("fw_drain_valid", mf.rd_valid, 1);
            if (fq.size() != 0) begin
                e = fq.pop_front();
                chk("fw_drain_data", mf.rd_data, e);
            end
            mf.rd_en = 1'b1;
            tick();
            if (i == 0) chk("fw_ovf_pulse", mf.overflow, 0);
        end
        chk("fw_drained_valid", mf.rd_valid, 0);
        chk("fw_drained_count", mf.count, 0);
        tick();
        mf.rd_en = 1'b0;
        chk("fw_underflow", mf.underflow, 1);

`ifdef SHALLOW_FIFO_PARITY_EN
        do_reset();
        ms.wr_en = 1'b1; ms.wr_data = 8'h3C;
        tick();
        ms.wr_en = 1'b0;
        dut_s.mem[0] = dut_s.mem[0] ^ 9'h001;
        ms.rd_en = 1'b1;
        tick();
        ms.rd_en = 1'b0;
        chk("par_err", ms.parity_err, 1);
        chk("par_data", ms.rd_data, 8'h3D);
        tick();
        chk("par_pulse", ms.parity_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
